// File: rtl/port_rd_arbiter.sv
// Round-robin owner of the shared SRAM read port: grants one port, bursts its packet words, pulses rd_done.
// Grant one cycle after request in IDLE; strobes stall while sram_ready is low; DONE and IDLE separate bursts.
module port_rd_arbiter #(
  parameter int PORT_NUM = 4,
  parameter int ADDR_W   = 11,
  parameter int LEN_W    = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORT_NUM-1:0]          rd_req,
  input  logic [PORT_NUM*ADDR_W-1:0]   rd_head_addr,
  input  logic [PORT_NUM*LEN_W-1:0]    rd_len,
  input  logic                         sram_ready,
  output logic                         sram_rd_en,
  output logic [ADDR_W-1:0]            sram_rd_addr,
  output logic [PORT_NUM-1:0]          rd_grant,
  output logic [PORT_NUM-1:0]          rd_done,
  output logic                         busy
);

  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       last_grant, grant_idx, win_idx;
  logic                win_vld;
  logic [ADDR_W-1:0]   addr_q, win_addr;
  logic [LEN_W-1:0]    len_q, cnt, win_len;
  logic [PORT_NUM-1:0] grant_oh;
  logic                last_word;

  // Search starts just after the previous owner, so the previous owner has lowest priority.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= PORT_NUM; k++) begin
      if (!win_vld && rd_req[PW'((int'(last_grant) + k) % PORT_NUM)]) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(last_grant) + k) % PORT_NUM);
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (win_idx == PW'(i)) begin
        win_addr = rd_head_addr[i*ADDR_W +: ADDR_W];
        win_len  = rd_len[i*LEN_W +: LEN_W];
      end
    end
    if (win_len == '0) win_len = LEN_W'(1);
  end

  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) grant_oh[i] = (grant_idx == PW'(i));
  end

  assign last_word    = (cnt == len_q - LEN_W'(1));
  assign sram_rd_addr = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sram_rd_en = 1'b0;
    rd_grant   = '0;
    rd_done    = '0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) state_nxt = BURST;
      end
      BURST: begin
        rd_grant   = grant_oh;
        busy       = 1'b1;
        sram_rd_en = sram_ready;
        if (sram_ready && last_word) state_nxt = DONE;
      end
      DONE: begin
        rd_grant  = grant_oh;
        rd_done   = grant_oh;
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request inputs are sampled only at the IDLE->BURST edge; the burst runs from the latched copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      len_q      <= '0;
      cnt        <= '0;
      grant_idx  <= '0;
      last_grant <= PW'(PORT_NUM - 1);
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant_idx <= win_idx;
            addr_q    <= win_addr;
            len_q     <= win_len;
            cnt       <= '0;
          end
        end
        BURST: begin
          if (sram_rd_en) begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt    <= cnt + LEN_W'(1);
          end
        end
        DONE:    last_grant <= grant_idx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_port_rd_arbiter.sv
// Directed vector table plus a hand sequence for asynchronous reset during a burst.
module tb_port_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rd_req = '0;
  logic [43:0] rd_head_addr = '0;
  logic [27:0] rd_len = '0;
  logic        sram_ready = 1'b0;
  logic        sram_rd_en;
  logic [10:0] sram_rd_addr;
  logic [3:0]  rd_grant;
  logic [3:0]  rd_done;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  port_rd_arbiter #(.PORT_NUM(4), .ADDR_W(11), .LEN_W(7)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_head_addr(rd_head_addr), .rd_len(rd_len),
    .sram_ready(sram_ready), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
    .rd_grant(rd_grant), .rd_done(rd_done), .busy(busy)
  );

  typedef struct {
    logic        pre_rst;
    logic [3:0]  req;
    logic [43:0] head;
    logic [27:0] len;
    logic        ready;
    logic        en;
    logic [10:0] addr;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  localparam logic [43:0] HA  = {11'h000, 11'h010, 11'h000, 11'h000};
  localparam logic [27:0] LA  = {7'd0, 7'd3, 7'd0, 7'd0};
  localparam logic [43:0] HB  = {11'h130, 11'h120, 11'h110, 11'h100};
  localparam logic [27:0] LB  = {7'd1, 7'd1, 7'd1, 7'd1};
  localparam logic [43:0] HC  = {11'h000, 11'h000, 11'h000, 11'h200};
  localparam logic [27:0] LC  = {7'd0, 7'd0, 7'd0, 7'd4};
  localparam logic [43:0] HD  = {11'h000, 11'h000, 11'h7FE, 11'h000};
  localparam logic [27:0] LD  = {7'd0, 7'd0, 7'd3, 7'd0};
  localparam logic [43:0] HD2 = {11'h000, 11'h000, 11'h055, 11'h000};
  localparam logic [27:0] LD2 = {7'd0, 7'd0, 7'd0, 7'd0};
  localparam logic [43:0] HE  = {11'h000, 11'h320, 11'h000, 11'h300};
  localparam logic [27:0] LE  = {7'd0, 7'd1, 7'd0, 7'd3};
  localparam logic [43:0] HE2 = {11'h000, 11'h320, 11'h000, 11'h3AA};
  localparam logic [27:0] LE2 = {7'd0, 7'd1, 7'd0, 7'd5};

  task automatic add(input logic pr, input logic [3:0] req, input logic [43:0] head,
                     input logic [27:0] len, input logic rdy, input logic en,
                     input logic [10:0] addr, input logic [3:0] g, input logic [3:0] d,
                     input logic b);
    vec_t v;
    v.pre_rst = pr; v.req = req; v.head = head; v.len = len; v.ready = rdy;
    v.en = en; v.addr = addr; v.grant = g; v.done = d; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic en, input logic [10:0] addr,
                     input logic [3:0] g, input logic [3:0] d, input logic b);
    tests++;
    if ({sram_rd_en, sram_rd_addr, rd_grant, rd_done, busy} !== {en, addr, g, d, b}) begin
      fails++;
      $display("FAIL %s: got en=%b addr=%h grant=%b done=%b busy=%b, expected en=%b addr=%h grant=%b done=%b busy=%b",
               name, sram_rd_en, sram_rd_addr, rd_grant, rd_done, busy, en, addr, g, d, b);
    end
  endtask

  initial begin
    // Each row: inputs for this cycle, outputs expected before the next rising edge.
    // Single request on port 2, length 3.
    add(1, 4'b0100, HA, LA, 1, 0, 11'h000, 4'b0000, 4'b0000, 0);
    add(0, 4'b0100, HA, LA, 1, 1, 11'h010, 4'b0100, 4'b0000, 1);
    add(0, 4'b0100, HA, LA, 1, 1, 11'h011, 4'b0100, 4'b0000, 1);
    add(0, 4'b0100, HA, LA, 1, 1, 11'h012, 4'b0100, 4'b0000, 1);
    add(0, 4'b0100, HA, LA, 1, 0, 11'h013, 4'b0100, 4'b0100, 1);
    add(0, 4'b0000, HA, LA, 1, 0, 11'h013, 4'b0000, 4'b0000, 0);
    // All ports requesting, length 1: order 0,1,2,3,0.
    add(1, 4'b1111, HB, LB, 1, 0, 11'h000, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, HB, LB, 1, 1, 11'h100, 4'b0001, 4'b0000, 1);
    add(0, 4'b1111, HB, LB, 1, 0, 11'h101, 4'b0001, 4'b0001, 1);
    add(0, 4'b1111, HB, LB, 1, 0, 11'h101, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, HB, LB, 1, 1, 11'h110, 4'b0010, 4'b0000, 1);
    add(0, 4'b1111, HB, LB, 1, 0, 11'h111, 4'b0010, 4'b0010, 1);
    add(0, 4'b1111, HB, LB, 1, 0, 11'h111, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, HB, LB, 1, 1, 11'h120, 4'b0100, 4'b0000, 1);
    add(0, 4'b1111, HB, LB, 1, 0, 11'h121, 4'b0100, 4'b0100, 1);
    add(0, 4'b1111, HB, LB, 1, 0, 11'h121, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, HB, LB, 1, 1, 11'h130, 4'b1000, 4'b0000, 1);
    add(0, 4'b1111, HB, LB, 1, 0, 11'h131, 4'b1000, 4'b1000, 1);
    add(0, 4'b1111, HB, LB, 1, 0, 11'h131, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, HB, LB, 1, 1, 11'h100, 4'b0001, 4'b0000, 1);
    // Backpressure, length 4, ready 1,0,0,1,1,0,1.
    add(1, 4'b0001, HC, LC, 1, 0, 11'h000, 4'b0000, 4'b0000, 0);
    add(0, 4'b0001, HC, LC, 1, 1, 11'h200, 4'b0001, 4'b0000, 1);
    add(0, 4'b0001, HC, LC, 0, 0, 11'h201, 4'b0001, 4'b0000, 1);
    add(0, 4'b0001, HC, LC, 0, 0, 11'h201, 4'b0001, 4'b0000, 1);
    add(0, 4'b0001, HC, LC, 1, 1, 11'h201, 4'b0001, 4'b0000, 1);
    add(0, 4'b0001, HC, LC, 1, 1, 11'h202, 4'b0001, 4'b0000, 1);
    add(0, 4'b0001, HC, LC, 0, 0, 11'h203, 4'b0001, 4'b0000, 1);
    add(0, 4'b0001, HC, LC, 1, 1, 11'h203, 4'b0001, 4'b0000, 1);
    add(0, 4'b0001, HC, LC, 1, 0, 11'h204, 4'b0001, 4'b0001, 1);
    add(0, 4'b0000, HC, LC, 1, 0, 11'h204, 4'b0000, 4'b0000, 0);
    // Address wrap on port 1, then a zero-length packet.
    add(1, 4'b0010, HD, LD, 1, 0, 11'h000, 4'b0000, 4'b0000, 0);
    add(0, 4'b0010, HD, LD, 1, 1, 11'h7FE, 4'b0010, 4'b0000, 1);
    add(0, 4'b0010, HD, LD, 1, 1, 11'h7FF, 4'b0010, 4'b0000, 1);
    add(0, 4'b0010, HD, LD, 1, 1, 11'h000, 4'b0010, 4'b0000, 1);
    add(0, 4'b0010, HD, LD, 1, 0, 11'h001, 4'b0010, 4'b0010, 1);
    add(0, 4'b0000, HD, LD, 1, 0, 11'h001, 4'b0000, 4'b0000, 0);
    add(0, 4'b0010, HD2, LD2, 1, 0, 11'h001, 4'b0000, 4'b0000, 0);
    add(0, 4'b0010, HD2, LD2, 1, 1, 11'h055, 4'b0010, 4'b0000, 1);
    add(0, 4'b0010, HD2, LD2, 1, 0, 11'h056, 4'b0010, 4'b0010, 1);
    add(0, 4'b0000, HD2, LD2, 1, 0, 11'h056, 4'b0000, 4'b0000, 0);
    // Owner withdraws and its inputs change mid-burst; port 2 waits, granted 2 cycles after DONE.
    add(1, 4'b0101, HE, LE, 1, 0, 11'h000, 4'b0000, 4'b0000, 0);
    add(0, 4'b0101, HE, LE, 1, 1, 11'h300, 4'b0001, 4'b0000, 1);
    add(0, 4'b0100, HE2, LE2, 1, 1, 11'h301, 4'b0001, 4'b0000, 1);
    add(0, 4'b0100, HE2, LE2, 1, 1, 11'h302, 4'b0001, 4'b0000, 1);
    add(0, 4'b0100, HE2, LE2, 1, 0, 11'h303, 4'b0001, 4'b0001, 1);
    add(0, 4'b0100, HE2, LE2, 1, 0, 11'h303, 4'b0000, 4'b0000, 0);
    add(0, 4'b0100, HE2, LE2, 1, 1, 11'h320, 4'b0100, 4'b0000, 1);
    add(0, 4'b0100, HE2, LE2, 1, 0, 11'h321, 4'b0100, 4'b0100, 1);
    add(0, 4'b0000, HE2, LE2, 1, 0, 11'h321, 4'b0000, 4'b0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].pre_rst) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
      rd_req       = vecs[i].req;
      rd_head_addr = vecs[i].head;
      rd_len       = vecs[i].len;
      sram_ready   = vecs[i].ready;
      #1;
      chk($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].grant, vecs[i].done, vecs[i].busy);
    end

    // Reset pulsed during word 2 of 5 on port 2, between clock edges.
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    rd_req       = 4'b0100;
    rd_head_addr = {11'h000, 11'h040, 11'h000, 11'h000};
    rd_len       = {7'd0, 7'd5, 7'd0, 7'd0};
    sram_ready   = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_word1", 1, 11'h040, 4'b0100, 4'b0000, 1);
    @(negedge clk);
    #1;
    chk("rst_word2", 1, 11'h041, 4'b0100, 4'b0000, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async", 0, 11'h000, 4'b0000, 4'b0000, 0);
    #1;
    rst = 1'b0;
    rd_req       = 4'b1101;
    rd_head_addr = {11'h000, 11'h000, 11'h000, 11'h0A0};
    rd_len       = {7'd1, 7'd1, 7'd1, 7'd1};
    @(negedge clk);
    #1;
    chk("rst_regrant", 1, 11'h0A0, 4'b0001, 4'b0000, 1);
    @(negedge clk);
    #1;
    chk("rst_regrant_done", 0, 11'h0A1, 4'b0001, 4'b0001, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
